mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter MULT_LAT, default 3: pipeline latency of the external MULT core, in clock edges from sampled a/b to valid p.
REQ-002 Parameter ARB_RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 highest.
REQ-003 clk  in  1  single system clock; all logic rises on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has an operand pair.
REQ-006 req0_ready  out  1  requester 0 pair accepted this cycle.
REQ-007 req0_a, req0_b  in  16 each  requester 0 signed operands.
REQ-008 req1_valid, req1_ready, req1_a, req1_b: same as REQ-005..007, for requester 1.
REQ-009 res0_valid  out  1  one-cycle pulse: res0_p holds requester 0's product.
REQ-010 res0_p  out  32  signed product for requester 0.
REQ-011 res1_valid, res1_p: same as REQ-009..010, for requester 1.
REQ-012 mult_a, mult_b  out  16 each  registered operands to the MULT core's a/b inputs.
REQ-013 mult_p  in  32  product from the MULT core's p output.
REQ-014 busy  out  1  high while any product is in flight.

Function
REQ-015 Acceptance: a transfer occurs on an edge where reqN_valid and reqN_ready are both high; at most one transfer per cycle.
REQ-016 reqN_ready shall be combinational from the grant decision and shall never be high unless reqN_valid is high.
REQ-017 Round-robin: if both requesters are valid, grant the requester not granted most recently; if one is valid, grant it.
REQ-018 The last-grant pointer shall update only on an accepting edge.
REQ-019 Fixed priority (ARB_RR=0): requester 0 always wins a tie.
REQ-020 On an accepting edge, mult_a/mult_b shall register the granted operands; on edges with no acceptance they shall register 0.
REQ-021 A tag pipeline of MULT_LAT+1 stages shall carry {valid, id} alongside each issued pair.
REQ-022 Latency: for a pair accepted at edge E, resID_valid shall be high during the cycle following edge E+MULT_LAT+1, with resID_p = mult_p in that cycle.
REQ-023 resN_p shall be registered; it shall hold its last value when resN_valid is low.
REQ-024 res0_valid and res1_valid shall never be high in the same cycle.
REQ-025 There is no result backpressure: one pair per cycle is sustained indefinitely, and results return in acceptance order.
REQ-026 Signed arithmetic: -32768 * -32768 = 0x40000000; no saturation; the product is passed through unmodified.
REQ-027 busy = OR of all tag-pipeline valid bits.

Reset
REQ-028 While rst is high: reqN_ready=0, resN_valid=0, resN_p=0, mult_a=mult_b=0, all tag valid bits=0, last-grant pointer=1 (so requester 0 wins the first tie), busy=0.
REQ-029 Reset mid-operation discards every in-flight product: no resN_valid pulse for pairs accepted before reset, even though mult_p may still carry their stale products.
REQ-030 The first acceptance is possible on the first edge after rst deasserts.

Structure
REQ-031 Package mult_arb_pkg shall hold OP_W=16, P_W=32, MULT_LAT_DEFAULT=3, and the tag struct/width (valid + 1-bit id).
REQ-032 Sub-module tag_pipe (parameterised depth, synchronous clear) shall implement the tag delay line; arbitration and datapath registers stay in mult_arbiter.
REQ-033 The MULT core shall be instantiated outside mult_arbiter; the bench shall connect the real core or a behavioural model with MULT_LAT latency.

Verification
REQ-034 Single request: req0 (-2, 15) -> res0_valid after MULT_LAT+1 edges with res0_p=0xFFFFFFE2; res1_valid stays low.
REQ-035 Contention: both valid for 4 cycles, req0 (6, 7) and req1 (4, 15) -> grants alternate 0,1,0,1; results 42 / 60 / 42 / 60 on alternating res ports.
REQ-036 Back-to-back streaming: req1 valid for 8 cycles, (8, 9) then incrementing a -> 8 consecutive res1_valid pulses, 72, 81, 90, ..., 135.
REQ-037 Reset mid-flight: accept 2 pairs, assert rst for 1 cycle -> no res pulses, busy=0 after reset, next request completes normally.
REQ-038 Corner: (-32768, -32768) -> 0x40000000; (-32768, 1) -> 0xFFFF8000.
REQ-039 ARB_RR=0 with both valid for 3 cycles -> requester 0 granted every cycle; req1_ready stays low.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared widths, default latency and the tag that rides alongside each
// operand pair through the external multiplier.
package mult_arb_pkg;
   localparam int OP_W             = 16;
   localparam int P_W              = 32;
   localparam int MULT_LAT_DEFAULT = 3;

   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);
endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, result and MULT-core signals of the two-port multiplier arbiter.
// The slave modport is the arbiter; master is the requester/core side.
interface mult_arbiter_if;
   import mult_arb_pkg::*;

   logic            req0_valid, req0_ready;
   logic [OP_W-1:0] req0_a, req0_b;
   logic            req1_valid, req1_ready;
   logic [OP_W-1:0] req1_a, req1_b;
   logic            res0_valid, res1_valid;
   logic [P_W-1:0]  res0_p, res1_p;
   logic [OP_W-1:0] mult_a, mult_b;
   logic [P_W-1:0]  mult_p;
   logic            busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mult_p,
      output req0_ready, req1_ready, res0_valid, res0_p, res1_valid, res1_p,
             mult_a, mult_b, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mult_p,
      input  req0_ready, req1_ready, res0_valid, res0_p, res1_valid, res1_p,
             mult_a, mult_b, busy
   );
endinterface

// File: rtl/mult_arbiter_tag_pipe.sv
// Delay line of {valid, id} tags with synchronous clear; dout is the oldest
// stage and any_vld flags that some tag is still in flight.
module tag_pipe
   import mult_arb_pkg::*;
#(
   parameter int DEPTH = MULT_LAT_DEFAULT + 1
) (
   input  logic clk,
   input  logic clr,
   input  tag_t din,
   output tag_t dout,
   output logic any_vld
);
   tag_t [DEPTH-1:0] stage;
   logic [DEPTH-1:0] vld_pipe;

   always_ff @(posedge clk) begin
      if (clr) stage <= '0;
      else     stage <= {stage[DEPTH-2:0], din};
   end

   always_comb begin
      vld_pipe = '0;
      for (int i = 0; i < DEPTH; i++) vld_pipe[i] = stage[i].vld;
   end

   assign dout    = stage[DEPTH-1];
   assign any_vld = |vld_pipe;
endmodule

// File: rtl/mult_arbiter.sv
// Two-requester front end for a pipelined multiplier: arbitrates one pair per
// cycle, registers operands to the core and steers products back by tag.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEFAULT,
   parameter bit ARB_RR   = 1'b1
) (
   input logic            clk,
   input logic            rst,
   mult_arbiter_if.slave  bus
);
   logic            last_gnt;
   logic            gnt_id;
   logic            ready0, ready1, accept;
   logic [OP_W-1:0] mult_a, mult_b;
   logic            res0_valid, res1_valid;
   logic [P_W-1:0]  res0_p, res1_p;
   tag_t            tag_in, tag_out;
   logic            busy;

   // On a tie round-robin picks the requester not served last; with only one
   // valid requester the grant simply follows it.
   always_comb begin
      gnt_id = ~bus.req0_valid;
      if (ARB_RR && bus.req0_valid && bus.req1_valid) gnt_id = ~last_gnt;
   end

   assign ready0 = !rst && bus.req0_valid && !gnt_id;
   assign ready1 = !rst && bus.req1_valid &&  gnt_id;
   assign accept = ready0 | ready1;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
         mult_a   <= '0;
         mult_b   <= '0;
      end else begin
         if (accept) last_gnt <= gnt_id;
         mult_a <= accept ? (gnt_id ? bus.req1_a : bus.req0_a) : '0;
         mult_b <= accept ? (gnt_id ? bus.req1_b : bus.req0_b) : '0;
      end
   end

   assign tag_in = '{vld: accept, id: gnt_id};

   // Tail stage lines up with the core's product; the result register adds
   // the final edge of latency.
   tag_pipe #(.DEPTH(MULT_LAT + 1)) u_tag_pipe (
      .clk     (clk),
      .clr     (rst),
      .din     (tag_in),
      .dout    (tag_out),
      .any_vld (busy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res0_p     <= '0;
         res1_p     <= '0;
      end else begin
         res0_valid <= tag_out.vld && !tag_out.id;
         res1_valid <= tag_out.vld &&  tag_out.id;
         if (tag_out.vld && !tag_out.id) res0_p <= bus.mult_p;
         if (tag_out.vld &&  tag_out.id) res1_p <= bus.mult_p;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.mult_a     = mult_a;
   assign bus.mult_b     = mult_b;
   assign bus.res0_valid = res0_valid;
   assign bus.res1_valid = res1_valid;
   assign bus.res0_p     = res0_p;
   assign bus.res1_p     = res1_p;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter, each feeding a
// behavioural multiplier with MULT_LAT latency.
module tb_mult_arbiter;
   import mult_arb_pkg::*;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_arbiter_if ifa ();
   mult_arbiter_if ifb ();

   mult_arbiter #(.MULT_LAT(LAT), .ARB_RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ifa));
   mult_arbiter #(.MULT_LAT(LAT), .ARB_RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ifb));

   // Behavioural cores: sampled at an edge, product visible LAT edges later.
   // No reset, so stale products linger exactly like a real core.
   logic [P_W-1:0] pa [LAT];
   logic [P_W-1:0] pb [LAT];
   always @(posedge clk) begin
      pa[0] <= $signed(ifa.mult_a) * $signed(ifa.mult_b);
      pb[0] <= $signed(ifb.mult_a) * $signed(ifb.mult_b);
      for (int i = 1; i < LAT; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end
   assign ifa.mult_p = pa[LAT-1];
   assign ifb.mult_p = pb[LAT-1];

   int          cyc = 0;
   int          both_hi = 0;
   logic [32:0] qa[$];
   logic [32:0] qb[$];
   int          qa_cyc[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (ifa.res0_valid) begin qa.push_back({1'b0, ifa.res0_p}); qa_cyc.push_back(cyc); end
      if (ifa.res1_valid) begin qa.push_back({1'b1, ifa.res1_p}); qa_cyc.push_back(cyc); end
      if (ifb.res0_valid) qb.push_back({1'b0, ifb.res0_p});
      if (ifb.res1_valid) qb.push_back({1'b1, ifb.res1_p});
      if (ifa.res0_valid && ifa.res1_valid) both_hi = both_hi + 1;
      if (ifb.res0_valid && ifb.res1_valid) both_hi = both_hi + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [32:0] exp2 [4];
   logic [32:0] exp5 [2];

   initial begin
      ifa.req0_valid = 1'b0; ifa.req0_a = '0; ifa.req0_b = '0;
      ifa.req1_valid = 1'b0; ifa.req1_a = '0; ifa.req1_b = '0;
      ifb.req0_valid = 1'b0; ifb.req0_a = '0; ifb.req0_b = '0;
      ifb.req1_valid = 1'b0; ifb.req1_a = '0; ifb.req1_b = '0;
      for (int i = 0; i < LAT; i++) begin pa[i] = '0; pb[i] = '0; end
      rst = 1'b1;
      ifa.req0_valid = 1'b1;  // ready must stay low while reset is held
      repeat (2) @(negedge clk);
      chk("rst_ready0", ifa.req0_ready, 0);
      chk("rst_res0_valid", ifa.res0_valid, 0);
      chk("rst_res0_p", ifa.res0_p, 0);
      chk("rst_mult_a", ifa.mult_a, 0);
      chk("rst_busy", ifa.busy, 0);

      // Single request, accepted on the first edge after reset
      rst = 1'b0;
      ifa.req0_a = 16'hFFFE; ifa.req0_b = 16'd15;
      #1;
      chk("t1_ready0", ifa.req0_ready, 1);
      chk("t1_ready1", ifa.req1_ready, 0);
      @(negedge clk);
      ifa.req0_valid = 1'b0;
      #1;
      chk("t1_ready0_idle", ifa.req0_ready, 0);
      chk("t1_mult_a", ifa.mult_a, 16'hFFFE);
      chk("t1_busy", ifa.busy, 1);
      repeat (3) @(negedge clk);
      chk("t1_early", ifa.res0_valid, 0);
      @(negedge clk);
      chk("t1_res0_valid", ifa.res0_valid, 1);
      chk("t1_res0_p", ifa.res0_p, 32'hFFFFFFE2);
      chk("t1_res1_valid", ifa.res1_valid, 0);
      chk("t1_busy_done", ifa.busy, 0);
      @(negedge clk);
      chk("t1_pulse_end", ifa.res0_valid, 0);
      chk("t1_hold_p", ifa.res0_p, 32'hFFFFFFE2);
      qa.delete(); qa_cyc.delete();

      // Contention: reset restores the pointer so requester 0 wins first
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ifa.req0_valid = 1'b1; ifa.req0_a = 16'd6; ifa.req0_b = 16'd7;
      ifa.req1_valid = 1'b1; ifa.req1_a = 16'd4; ifa.req1_b = 16'd15;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t2_ready0_%0d", k), ifa.req0_ready, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("t2_ready1_%0d", k), ifa.req1_ready, (k % 2 == 1) ? 1 : 0);
         @(negedge clk);
      end
      ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
      repeat (8) @(negedge clk);
      exp2[0] = {1'b0, 32'd42}; exp2[1] = {1'b1, 32'd60};
      exp2[2] = {1'b0, 32'd42}; exp2[3] = {1'b1, 32'd60};
      chk("t2_count", qa.size(), 4);
      for (int k = 0; k < 4 && k < qa.size(); k++)
         chk($sformatf("t2_res_%0d", k), qa[k], exp2[k]);
      qa.delete(); qa_cyc.delete();

      // Back-to-back streaming on requester 1
      ifa.req1_valid = 1'b1; ifa.req1_b = 16'd9;
      for (int k = 0; k < 8; k++) begin
         ifa.req1_a = 16'(8 + k);
         #1;
         chk($sformatf("t3_ready1_%0d", k), ifa.req1_ready, 1);
         @(negedge clk);
      end
      ifa.req1_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3_count", qa.size(), 8);
      for (int k = 0; k < 8 && k < qa.size(); k++)
         chk($sformatf("t3_res_%0d", k), qa[k], {1'b1, 32'((8 + k) * 9)});
      if (qa_cyc.size() == 8) chk("t3_consecutive", qa_cyc[7] - qa_cyc[0], 7);
      qa.delete(); qa_cyc.delete();

      // Reset while two products are in flight
      ifa.req0_valid = 1'b1; ifa.req0_a = 16'd3; ifa.req0_b = 16'd3;
      @(negedge clk);
      ifa.req0_a = 16'd5; ifa.req0_b = 16'd5;
      @(negedge clk);
      ifa.req0_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t4_busy_after_rst", ifa.busy, 0);
      repeat (8) @(negedge clk);
      chk("t4_discarded", qa.size(), 0);
      ifa.req0_valid = 1'b1; ifa.req0_a = 16'd7; ifa.req0_b = 16'd7;
      @(negedge clk);
      ifa.req0_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("t4_next_count", qa.size(), 1);
      if (qa.size() > 0) chk("t4_next_res", qa[0], {1'b0, 32'd49});
      qa.delete(); qa_cyc.delete();

      // Signed corners
      ifa.req0_valid = 1'b1; ifa.req0_a = 16'h8000; ifa.req0_b = 16'h8000;
      @(negedge clk);
      ifa.req0_b = 16'd1;
      @(negedge clk);
      ifa.req0_valid = 1'b0;
      repeat (8) @(negedge clk);
      exp5[0] = {1'b0, 32'h40000000}; exp5[1] = {1'b0, 32'hFFFF8000};
      chk("t5_count", qa.size(), 2);
      for (int k = 0; k < 2 && k < qa.size(); k++)
         chk($sformatf("t5_res_%0d", k), qa[k], exp5[k]);

      // Fixed priority: requester 0 takes every tie
      ifb.req0_valid = 1'b1; ifb.req0_a = 16'd2; ifb.req0_b = 16'd3;
      ifb.req1_valid = 1'b1; ifb.req1_a = 16'd5; ifb.req1_b = 16'd5;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t6_ready0_%0d", k), ifb.req0_ready, 1);
         chk($sformatf("t6_ready1_%0d", k), ifb.req1_ready, 0);
         @(negedge clk);
      end
      ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_count", qb.size(), 3);
      for (int k = 0; k < 3 && k < qb.size(); k++)
         chk($sformatf("t6_res_%0d", k), qb[k], {1'b0, 32'd6});

      chk("res_exclusive", both_hi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
